// File: rtl/char_window_reader.sv
// char_window_reader: maps VGA pixel counters onto a (possibly wrapped)
// character window, fetches bitmap bits and drives the RGB pins.
module char_window_reader #(
  parameter int HDR  = 640,
  parameter int VDR  = 480,
  parameter int HAL  = 16,
  parameter int VAL  = 16,
  parameter int CHM  = 4,
  parameter int RGBW = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pixEn,
  input  logic [9:0]               hCnt,
  input  logic [9:0]               vCnt,
  input  logic                     visible,
  input  logic                     frameStart,
  input  logic [9:0]               posHorStart,
  input  logic [9:0]               posHorEnd,
  input  logic [9:0]               posVerStart,
  input  logic [9:0]               posVerEnd,
  input  logic                     memBit,
  input  logic [RGBW-1:0]          fgColor,
  input  logic [RGBW-1:0]          bgColor,
  output logic                     readEn,
  output logic [$clog2(VAL)-1:0]   rowCnt,
  output logic [$clog2(HAL)-1:0]   colCnt,
  output logic [RGBW-1:0]          vgaRGB
);

  localparam int SH = $clog2(CHM);
  localparam int CW = $clog2(HAL);
  localparam int RW = $clog2(VAL);
  localparam logic [10:0] HDRW = 11'(HDR);
  localparam logic [10:0] VDRW = 11'(VDR);
  localparam logic [10:0] CMAX = 11'(HAL - 1);
  localparam logic [10:0] RMAX = 11'(VAL - 1);

  typedef enum logic {
    WAIT_FRAME,
    ACTIVE
  } state_t;

  state_t state;

  logic [9:0] hsSh;
  logic [9:0] heSh;
  logic [9:0] vsSh;
  logic [9:0] veSh;

  logic       sample;
  logic       run;
  logic [9:0] hs;
  logic [9:0] he;
  logic [9:0] vs;
  logic [9:0] ve;
  logic       inH;
  logic       inV;
  logic       inWin;
  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] colRaw;
  logic [10:0] rowRaw;
  logic [CW-1:0] colNext;
  logic [RW-1:0] rowNext;
  logic       v1;
  logic       w1;

  function automatic logic [10:0] wrapDiff(
    input logic [9:0]  c,
    input logic [9:0]  s,
    input logic [10:0] m
  );
    if (c >= s) wrapDiff = {1'b0, c} - {1'b0, s};
    else        wrapDiff = {1'b0, c} + m - {1'b0, s};
  endfunction

  function automatic logic inAxis(
    input logic [9:0] c,
    input logic [9:0] s,
    input logic [9:0] e
  );
    if (s <= e) inAxis = (c >= s) && (c <= e);
    else        inAxis = (c >= s) || (c <= e);
  endfunction

  assign sample = pixEn & frameStart;
  assign run    = (state == ACTIVE) | frameStart;

  // Bounds arriving with frameStart already govern pixel (0,0).
  always_comb begin
    hs = sample ? posHorStart : hsSh;
    he = sample ? posHorEnd   : heSh;
    vs = sample ? posVerStart : vsSh;
    ve = sample ? posVerEnd   : veSh;
  end

  // Window membership and saturated bitmap indices for the current pixel.
  always_comb begin
    inH     = inAxis(hCnt, hs, he);
    inV     = inAxis(vCnt, vs, ve);
    inWin   = visible & inH & inV;
    dx      = wrapDiff(hCnt, hs, HDRW);
    dy      = wrapDiff(vCnt, vs, VDRW);
    colRaw  = dx >> SH;
    rowRaw  = dy >> SH;
    colNext = (colRaw > CMAX) ? CW'(HAL - 1) : colRaw[CW-1:0];
    rowNext = (rowRaw > RMAX) ? RW'(VAL - 1) : rowRaw[RW-1:0];
  end

  // Frame FSM; shadow bounds latch only at frame start to avoid tearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_FRAME;
      hsSh  <= '0;
      heSh  <= '0;
      vsSh  <= '0;
      veSh  <= '0;
    end else begin
      case (state)
        WAIT_FRAME: if (sample) state <= ACTIVE;
        ACTIVE:     state <= ACTIVE;
        default:    state <= WAIT_FRAME;
      endcase
      if (sample) begin
        hsSh <= posHorStart;
        heSh <= posHorEnd;
        vsSh <= posVerStart;
        veSh <= posVerEnd;
      end
    end
  end

  // Stage 1: issue the memory read and carry pixel qualifiers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readEn <= 1'b0;
      rowCnt <= '0;
      colCnt <= '0;
      v1     <= 1'b0;
      w1     <= 1'b0;
    end else if (pixEn) begin
      if (run) begin
        readEn <= inWin;
        v1     <= visible;
        w1     <= inWin;
        if (inWin) begin
          rowCnt <= rowNext;
          colCnt <= colNext;
        end
      end else begin
        readEn <= 1'b0;
        v1     <= 1'b0;
        w1     <= 1'b0;
      end
    end
  end

  // Stage 2: pick the colour once the bitmap bit has returned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vgaRGB <= '0;
    end else if (pixEn) begin
      if (!v1)              vgaRGB <= '0;
      else if (w1 & memBit) vgaRGB <= fgColor;
      else                  vgaRGB <= bgColor;
    end
  end

endmodule

// File: tb/tb_char_window_reader.sv
// tb_char_window_reader: random pixel streams over several window shapes,
// compared cycle by cycle against a pixel-level reference model.
module tb_char_window_reader;

  localparam int HDR = 640;
  localparam int VDR = 480;
  localparam int HAL = 16;
  localparam int VAL = 16;
  localparam int CHM = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pixEn;
  logic [9:0] hCnt;
  logic [9:0] vCnt;
  logic       visible;
  logic       frameStart;
  logic [9:0] posHorStart;
  logic [9:0] posHorEnd;
  logic [9:0] posVerStart;
  logic [9:0] posVerEnd;
  logic       memBit;
  logic [8:0] fgColor;
  logic [8:0] bgColor;
  logic       readEn;
  logic [3:0] rowCnt;
  logic [3:0] colCnt;
  logic [8:0] vgaRGB;

  char_window_reader dut (
    .clk         (clk),
    .reset       (reset),
    .pixEn       (pixEn),
    .hCnt        (hCnt),
    .vCnt        (vCnt),
    .visible     (visible),
    .frameStart  (frameStart),
    .posHorStart (posHorStart),
    .posHorEnd   (posHorEnd),
    .posVerStart (posVerStart),
    .posVerEnd   (posVerEnd),
    .memBit      (memBit),
    .fgColor     (fgColor),
    .bgColor     (bgColor),
    .readEn      (readEn),
    .rowCnt      (rowCnt),
    .colCnt      (colCnt),
    .vgaRGB      (vgaRGB)
  );

  always #5 clk = ~clk;

  int nChk;
  int nFail;

  bit bmp [16][16];

  int mHs, mHe, mVs, mVe;
  bit mActive;
  int expRow, expCol;
  bit expRead;
  int pendKind;
  int expVga;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit inAx(int c, int s, int e);
    if (s <= e) return (c >= s) && (c <= e);
    return (c >= s) || (c <= e);
  endfunction

  function automatic int idx(int c, int s, int m, int lim);
    int d;
    d = c - s;
    if (d < 0) d += m;
    d = d / CHM;
    if (d > lim - 1) d = lim - 1;
    return d;
  endfunction

  task automatic resetModel();
    mActive  = 0;
    expRead  = 0;
    expRow   = 0;
    expCol   = 0;
    pendKind = 0;
    expVga   = 0;
  endtask

  task automatic modelPix(bit fs, bit vis, int h, int v);
    bit w;
    int k;
    expVga = (pendKind == 2) ? int'(fgColor) :
             (pendKind == 1) ? int'(bgColor) : 0;
    if (fs) begin
      mHs = posHorStart;
      mHe = posHorEnd;
      mVs = posVerStart;
      mVe = posVerEnd;
      mActive = 1;
    end
    if (!mActive) begin
      expRead = 0;
      k = 0;
    end else begin
      w = vis && inAx(h, mHs, mHe) && inAx(v, mVs, mVe);
      expRead = w;
      if (w) begin
        expCol = idx(h, mHs, HDR, HAL);
        expRow = idx(v, mVs, VDR, VAL);
      end
      if (!vis)    k = 0;
      else if (!w) k = 1;
      else         k = bmp[expRow][expCol] ? 2 : 1;
    end
    pendKind = k;
  endtask

  task automatic checkAll();
    check("readEn", readEn, expRead);
    check("rowCnt", rowCnt, expRow);
    check("colCnt", colCnt, expCol);
    check("vgaRGB", vgaRGB, expVga);
  endtask

  task automatic cycle(bit pe, bit fs, bit vis, int h, int v);
    @(negedge clk);
    memBit     = readEn ? bmp[rowCnt][colCnt] : 1'($urandom);
    pixEn      = pe;
    frameStart = fs;
    visible    = vis;
    hCnt       = 10'(h);
    vCnt       = 10'(v);
    @(posedge clk);
    #1;
    if (pe) modelPix(fs, vis, h, v);
    checkAll();
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    resetModel();
    checkAll();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic scanLine(int v);
    for (int h = 0; h < HDR; h++) begin
      if ($urandom_range(5) == 0)
        repeat ($urandom_range(3, 1))
          cycle(0, 1'($urandom), 1'($urandom), $urandom_range(1023), v);
      cycle(1, 0, $urandom_range(15) != 0, h, v);
    end
    repeat (4) cycle(1, 0, 0, $urandom_range(1023), v);
  endtask

  task automatic setBounds(int hs, int he, int vs, int ve);
    posHorStart = 10'(hs);
    posHorEnd   = 10'(he);
    posVerStart = 10'(vs);
    posVerEnd   = 10'(ve);
  endtask

  task automatic frame(int hs, int he, int vs, int ve,
                       bit fsVis, bit midReset);
    int lines [6];
    if (hs >= 0) setBounds(hs, he, vs, ve);
    vs = posVerStart;
    ve = posVerEnd;
    lines[0] = (vs + VDR - 1) % VDR;
    lines[1] = vs;
    lines[2] = (vs + $urandom_range(63)) % VDR;
    lines[3] = ve;
    lines[4] = (ve + 1) % VDR;
    lines[5] = $urandom_range(VDR - 1);
    cycle(1, 1, fsVis, 0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2)
        setBounds($urandom_range(HDR - 1), $urandom_range(HDR - 1),
                  $urandom_range(VDR - 1), $urandom_range(VDR - 1));
      if (midReset && i == 3) doReset();
      scanLine(lines[i]);
    end
  endtask

  initial begin
    nChk = 0;
    nFail = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        bmp[r][c] = (r < 8) ? c[0] : 1'($urandom);
    reset      = 1'b1;
    pixEn      = 1'b0;
    frameStart = 1'b0;
    visible    = 1'b0;
    hCnt       = '0;
    vCnt       = '0;
    memBit     = 1'b0;
    fgColor    = 9'h1C0;
    bgColor    = 9'h007;
    setBounds(0, 0, 0, 0);
    resetModel();
    #1;
    checkAll();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 40; i++)
      cycle(1'($urandom), 0, 1'($urandom),
            $urandom_range(HDR - 1), $urandom_range(VDR - 1));

    frame(288, 351, 208, 271, 1, 0);
    frame(608, 31, 208, 271, 1, 0);
    fgColor = 9'($urandom);
    bgColor = 9'($urandom);
    frame(100, 163, 448, 31, 1, 0);
    frame(320, 320, 5, 5, 1, 0);
    frame(-1, 0, 0, 0, 0, 0);
    fgColor = 9'h1C0;
    bgColor = 9'h007;
    frame($urandom_range(HDR - 1), $urandom_range(HDR - 1),
          $urandom_range(VDR - 1), $urandom_range(VDR - 1), 1, 1);
    frame(288, 351, 208, 271, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
